// File: rtl/note_associator.sv
// Note-track associator: snapshots one frame of peak slots, matches each peak to the nearest
// active track by circular distance, starts tracks for unmatched peaks, then decays idle tracks.
module note_associator #(
    parameter int             N           = 16,
    parameter int             BPO         = 24,
    parameter int             SLOTS       = 12,
    parameter int             NOTES       = 12,
    parameter logic [N-1:0]   MATCH_DIST  = 16'h0400,
    parameter int             AMP_SHIFT   = 2,
    parameter int             DECAY_SHIFT = 3,
    parameter logic [N-1:0]   KILL_AMP    = 16'd64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        peaksReady,
    input  logic [SLOTS-1:0][N-1:0]     peakPos,
    input  logic [SLOTS-1:0][N-1:0]     peakAmp,
    input  logic [SLOTS-1:0]            peakValid,
    output logic [NOTES-1:0][N-1:0]     notePos,
    output logic [NOTES-1:0][N-1:0]     noteAmp,
    output logic [NOTES-1:0]            noteActive,
    output logic                        busy,
    output logic                        done,
    output logic                        dropped
);

    localparam int         FPF  = N - $clog2(BPO);
    localparam logic [N:0] SPAN = (N+1)'(BPO << FPF);
    localparam int         SW   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int         NW   = (NOTES > 1) ? $clog2(NOTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COMPARE = 3'd1,
        S_COMMIT  = 3'd2,
        S_DECAY   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [SLOTS-1:0][N-1:0]   snap_pos_q, snap_pos_d;
    logic [SLOTS-1:0][N-1:0]   snap_amp_q, snap_amp_d;
    logic [SLOTS-1:0]          snap_valid_q, snap_valid_d;
    logic [NOTES-1:0][N-1:0]   note_pos_q, note_pos_d;
    logic [NOTES-1:0][N-1:0]   note_amp_q, note_amp_d;
    logic [NOTES-1:0]          note_active_q, note_active_d;
    logic [NOTES-1:0]          matched_q, matched_d;
    logic [SW-1:0]             slot_q, slot_d;
    logic [NW-1:0]             idx_q, idx_d;
    logic                      found_q, found_d;
    logic [NW-1:0]             best_idx_q, best_idx_d;
    logic [N:0]                best_dist_q, best_dist_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      dropped_q, dropped_d;

    logic [N-1:0]              cur_pos_s, cur_amp_s, decayed_s, blended_s;
    logic [N:0]                a_ext_s, b_ext_s, d_raw_s, d_wrap_s, dist_s;
    logic                      cand_s, free_found_s;
    logic [NW-1:0]             free_idx_s;

    // Datapath helpers: circular distance, lowest free track, amplitude arithmetic.
    always_comb begin
        cur_pos_s = snap_pos_q[slot_q];
        cur_amp_s = snap_amp_q[slot_q];
        a_ext_s   = {1'b0, cur_pos_s};
        b_ext_s   = {1'b0, note_pos_q[idx_q]};
        d_raw_s   = (a_ext_s >= b_ext_s) ? (a_ext_s - b_ext_s) : (b_ext_s - a_ext_s);
        d_wrap_s  = SPAN - d_raw_s;
        dist_s    = (d_wrap_s < d_raw_s) ? d_wrap_s : d_raw_s;
        cand_s    = note_active_q[idx_q] & ~matched_q[idx_q] & (dist_s <= {1'b0, MATCH_DIST});

        free_found_s = 1'b0;
        free_idx_s   = {NW{1'b0}};
        for (int i = NOTES - 1; i >= 0; i--) begin
            free_idx_s   = note_active_q[i] ? free_idx_s : NW'(i);
            free_found_s = free_found_s | ~note_active_q[i];
        end

        decayed_s = note_amp_q[idx_q] - (note_amp_q[idx_q] >> DECAY_SHIFT);
        blended_s = note_amp_q[best_idx_q] - (note_amp_q[best_idx_q] >> AMP_SHIFT)
                  + (cur_amp_s >> AMP_SHIFT);
    end

    // Next-state logic for the frame sequencer and all track registers.
    always_comb begin
        state_d       = state_q;
        snap_pos_d    = snap_pos_q;
        snap_amp_d    = snap_amp_q;
        snap_valid_d  = snap_valid_q;
        note_pos_d    = note_pos_q;
        note_amp_d    = note_amp_q;
        note_active_d = note_active_q;
        matched_d     = matched_q;
        slot_d        = slot_q;
        idx_d         = idx_q;
        found_d       = found_q;
        best_idx_d    = best_idx_q;
        best_dist_d   = best_dist_q;
        dropped_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (peaksReady) begin
                    snap_pos_d   = peakPos;
                    snap_amp_d   = peakAmp;
                    snap_valid_d = peakValid;
                    matched_d    = {NOTES{1'b0}};
                    slot_d       = {SW{1'b0}};
                    idx_d        = {NW{1'b0}};
                    found_d      = 1'b0;
                    state_d      = S_COMPARE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COMPARE: begin
                // Strict less-than on an ascending scan keeps the lower index on ties.
                if (cand_s && (!found_q || (dist_s < best_dist_q))) begin
                    found_d     = 1'b1;
                    best_idx_d  = idx_q;
                    best_dist_d = dist_s;
                end else begin
                    found_d = found_q;
                end
                if (idx_q == NW'(NOTES - 1)) begin
                    idx_d   = {NW{1'b0}};
                    state_d = S_COMMIT;
                end else begin
                    idx_d = idx_q + {{(NW-1){1'b0}}, 1'b1};
                end
            end
            S_COMMIT: begin
                if (snap_valid_q[slot_q]) begin
                    if (found_q) begin
                        note_pos_d[best_idx_q] = cur_pos_s;
                        note_amp_d[best_idx_q] = blended_s;
                        matched_d[best_idx_q]  = 1'b1;
                    end else if (free_found_s) begin
                        note_pos_d[free_idx_s]    = cur_pos_s;
                        note_amp_d[free_idx_s]    = cur_amp_s;
                        note_active_d[free_idx_s] = 1'b1;
                        matched_d[free_idx_s]     = 1'b1;
                    end else begin
                        dropped_d = 1'b1;
                    end
                end else begin
                    dropped_d = 1'b0;
                end
                found_d = 1'b0;
                if (slot_q == SW'(SLOTS - 1)) begin
                    slot_d  = {SW{1'b0}};
                    state_d = S_DECAY;
                end else begin
                    slot_d  = slot_q + {{(SW-1){1'b0}}, 1'b1};
                    state_d = S_COMPARE;
                end
            end
            S_DECAY: begin
                if (note_active_q[idx_q] && !matched_q[idx_q]) begin
                    if (decayed_s < KILL_AMP) begin
                        note_active_d[idx_q] = 1'b0;
                        note_amp_d[idx_q]    = {N{1'b0}};
                    end else begin
                        note_amp_d[idx_q] = decayed_s;
                    end
                end else begin
                    note_amp_d[idx_q] = note_amp_q[idx_q];
                end
                if (idx_q == NW'(NOTES - 1)) begin
                    idx_d   = {NW{1'b0}};
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + {{(NW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset discards any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            snap_pos_q    <= {(SLOTS*N){1'b0}};
            snap_amp_q    <= {(SLOTS*N){1'b0}};
            snap_valid_q  <= {SLOTS{1'b0}};
            note_pos_q    <= {(NOTES*N){1'b0}};
            note_amp_q    <= {(NOTES*N){1'b0}};
            note_active_q <= {NOTES{1'b0}};
            matched_q     <= {NOTES{1'b0}};
            slot_q        <= {SW{1'b0}};
            idx_q         <= {NW{1'b0}};
            found_q       <= 1'b0;
            best_idx_q    <= {NW{1'b0}};
            best_dist_q   <= {(N+1){1'b0}};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            dropped_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            snap_pos_q    <= snap_pos_d;
            snap_amp_q    <= snap_amp_d;
            snap_valid_q  <= snap_valid_d;
            note_pos_q    <= note_pos_d;
            note_amp_q    <= note_amp_d;
            note_active_q <= note_active_d;
            matched_q     <= matched_d;
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            found_q       <= found_d;
            best_idx_q    <= best_idx_d;
            best_dist_q   <= best_dist_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            dropped_q     <= dropped_d;
        end
    end

    assign notePos    = note_pos_q;
    assign noteAmp    = note_amp_q;
    assign noteActive = note_active_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dropped    = dropped_q;

endmodule
